// File: rtl/mon_pro_exp.sv
// Modular exponentiation core: res_out = m^e mod n using radix-2 Montgomery products and a
// left-to-right square-and-multiply ladder. Define MONPRO_EVEN_N_CHECK_EN to reject even moduli.
module mon_pro_exp #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  startInput,
   input  logic                  getResult,
   input  logic [DATA_WIDTH-1:0] m_input,
   input  logic [DATA_WIDTH-1:0] e_input,
   input  logic [DATA_WIDTH-1:0] n_input,
   output logic [3:0]            state,
   output logic [4:0]            exp_state,
   output logic [DATA_WIDTH-1:0] res_out
);
   localparam int W  = DATA_WIDTH;
   localparam int AW = DATA_WIDTH + 2;
   localparam int IW = $clog2(DATA_WIDTH);
   localparam int CW = $clog2(2 * DATA_WIDTH);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] R2_LAST  = CW'(2 * DATA_WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_LOAD = 4'd1, S_R2 = 4'd2, S_MBAR = 4'd3, S_XBAR = 4'd4, S_SQR = 4'd5,
      S_MUL = 4'd6, S_NEXT = 4'd7, S_FINAL = 4'd8, S_DONE = 4'd9, S_ERR = 4'd10
   } top_state_t;

   typedef enum logic [4:0] {
      M_IDLE = 5'b00001, M_LOAD = 5'b00010, M_ITER = 5'b00100, M_SUB = 5'b01000, M_DONE = 5'b10000
   } mm_state_t;

   top_state_t      state_reg, state_next;
   mm_state_t       mm_reg, mm_next;
   logic [W-1:0]    m_reg, e_reg, n_reg, acc_reg, mb_reg, xb_reg, res_reg;
   logic [W-1:0]    a_reg, b_reg, op_a, op_b;
   logic [W:0]      acc_dbl, acc_next;
   logic [CW-1:0]   cnt_reg;
   logic [IW-1:0]   bit_reg, j_reg;
   logic [AW-1:0]   t_reg, sum_b, sum_n, t_iter;
   logic            mm_active, mm_done;

   assign state     = state_reg;
   assign exp_state = mm_reg;
   assign res_out   = res_reg;

   assign mm_active = state_reg inside {S_MBAR, S_XBAR, S_SQR, S_MUL, S_FINAL};
   assign mm_done   = (mm_reg == M_DONE);

   // Modular doubling for R^2 mod n; acc stays below n so one subtraction suffices.
   assign acc_dbl  = {acc_reg, 1'b0};
   assign acc_next = (acc_dbl >= {1'b0, n_reg}) ? acc_dbl - {1'b0, n_reg} : acc_dbl;

   // One Montgomery step: t stays below 2n, so the sum never exceeds W+2 bits.
   assign sum_b  = t_reg + (a_reg[0] ? {2'b00, b_reg} : '0);
   assign sum_n  = sum_b[0] ? sum_b + {2'b00, n_reg} : sum_b;
   assign t_iter = sum_n >> 1;

   always_comb begin
      op_a = xb_reg;
      op_b = xb_reg;
      case (state_reg)
         S_MBAR:  begin op_a = m_reg;  op_b = acc_reg; end
         S_XBAR:  begin op_a = W'(1);  op_b = acc_reg; end
         S_MUL:   op_a = mb_reg;
         S_FINAL: op_b = W'(1);
         default: ;
      endcase
   end

   always_comb begin
      mm_next = mm_reg;
      case (mm_reg)
         M_IDLE:  if (mm_active) mm_next = M_LOAD;
         M_LOAD:  mm_next = M_ITER;
         M_ITER:  if (j_reg == BIT_LAST) mm_next = M_SUB;
         M_SUB:   mm_next = M_DONE;
         M_DONE:  mm_next = M_IDLE;
         default: mm_next = M_IDLE;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (startInput) state_next = S_LOAD;
`ifdef MONPRO_EVEN_N_CHECK_EN
         S_LOAD:  state_next = n_input[0] ? S_R2 : S_ERR;
`else
         S_LOAD:  state_next = S_R2;
`endif
         S_R2:    if (cnt_reg == R2_LAST) state_next = S_MBAR;
         S_MBAR:  if (mm_done) state_next = S_XBAR;
         S_XBAR:  if (mm_done) state_next = S_SQR;
         S_SQR:   if (mm_done) state_next = e_reg[bit_reg] ? S_MUL : S_NEXT;
         S_MUL:   if (mm_done) state_next = S_NEXT;
         S_NEXT:  state_next = (bit_reg == '0) ? S_FINAL : S_SQR;
         S_FINAL: if (mm_done) state_next = S_DONE;
         S_DONE:  if (getResult) state_next = S_IDLE;
         S_ERR:   if (getResult) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         m_reg     <= '0;
         e_reg     <= '0;
         n_reg     <= '0;
         acc_reg   <= '0;
         mb_reg    <= '0;
         xb_reg    <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         bit_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_LOAD: begin
               m_reg   <= m_input;
               e_reg   <= e_input;
               n_reg   <= n_input;
               acc_reg <= (n_input == W'(1)) ? '0 : W'(1);
               cnt_reg <= '0;
               bit_reg <= BIT_LAST;
`ifdef MONPRO_EVEN_N_CHECK_EN
               if (!n_input[0]) res_reg <= '0;
`endif
            end
            S_R2: begin
               acc_reg <= acc_next[W-1:0];
               cnt_reg <= cnt_reg + CW'(1);
            end
            S_MBAR:  if (mm_done) mb_reg <= t_reg[W-1:0];
            S_XBAR, S_SQR, S_MUL: if (mm_done) xb_reg <= t_reg[W-1:0];
            S_NEXT:  if (bit_reg != '0) bit_reg <= bit_reg - IW'(1);
            S_FINAL: if (mm_done) res_reg <= t_reg[W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mm_reg <= M_IDLE;
         t_reg  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         j_reg  <= '0;
      end else begin
         mm_reg <= mm_next;
         case (mm_reg)
            M_LOAD: begin
               t_reg <= '0;
               a_reg <= op_a;
               b_reg <= op_b;
               j_reg <= '0;
            end
            M_ITER: begin
               t_reg <= t_iter;
               a_reg <= a_reg >> 1;
               j_reg <= j_reg + IW'(1);
            end
            M_SUB: if (t_reg >= {2'b00, n_reg}) t_reg <= t_reg - {2'b00, n_reg};
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mon_pro_exp.sv
// Directed bench for mon_pro_exp: vector table, reference-model vectors and
// multi-cycle sequences (held start, ignored acks, mid-run reset, even modulus).
module tb_mon_pro_exp;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         startInput, getResult;
   logic [W-1:0] m_input, e_input, n_input;
   logic [3:0]   state;
   logic [4:0]   exp_state;
   logic [W-1:0] res_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] m;
      logic [W-1:0] e;
      logic [W-1:0] n;
      logic [W-1:0] res;
   } vec_t;

   vec_t vecs[5];

   mon_pro_exp #(.DATA_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .startInput(startInput), .getResult(getResult),
      .m_input(m_input), .e_input(e_input), .n_input(n_input),
      .state(state), .exp_state(exp_state), .res_out(res_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain square-and-multiply with wide remainders, LSB first.
   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] m, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
      logic [127:0] r, b, nn;
      nn = {64'd0, n};
      r  = 128'd1 % nn;
      b  = {64'd0, m} % nn;
      for (int k = 0; k < W; k++) begin
         if (e[k]) r = (r * b) % nn;
         b = (b * b) % nn;
      end
      return r[W-1:0];
   endfunction

   task automatic wait_end();
      int cyc = 0;
      while (!(state == 4'd9 || state == 4'd10) && cyc < 12000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Called at a falling edge; returns once LOAD has captured the operands.
   task automatic start_run(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
      m_input = m; e_input = e; n_input = n;
      startInput = 1'b1;
      @(negedge clk);
      startInput = 1'b0;
      @(negedge clk);
   endtask

   task automatic ack();
      getResult = 1'b1;
      @(negedge clk);
      getResult = 1'b0;
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] m, input logic [W-1:0] e,
                                input logic [W-1:0] n, input logic [W-1:0] exp);
      start_run(m, e, n);
      wait_end();
      $display("run %s: m=0x%0h e=0x%0h n=0x%0h res=0x%0h exp=0x%0h", name, m, e, n, res_out, exp);
      check({name, " state"}, W'(state), W'(9));
      check({name, " res"}, res_out, exp);
      check({name, " exp_state"}, W'(exp_state), W'(5'b00001));
      ack();
      check({name, " idle"}, W'(state), W'(0));
      check({name, " res held"}, res_out, exp);
   endtask

   initial begin
      logic [W-1:0] rm, re, rn;
      int cyc;

      vecs[0] = '{m: 64'd4,    e: 64'd13, n: 64'd497,  res: 64'd445};
      vecs[1] = '{m: 64'd77,   e: 64'd0,  n: 64'd1023, res: 64'd1};
      vecs[2] = '{m: 64'd0,    e: 64'd5,  n: 64'd1023, res: 64'd0};
      vecs[3] = '{m: 64'd5,    e: 64'd7,  n: 64'd1,    res: 64'd0};
      vecs[4] = '{m: 64'd1023, e: 64'd3,  n: 64'd1023, res: 64'd0};

      reset = 1'b0; startInput = 1'b0; getResult = 1'b0;
      m_input = '0; e_input = '0; n_input = '0;
      repeat (3) @(negedge clk);
      check("reset state", W'(state), W'(0));
      check("reset exp_state", W'(exp_state), W'(5'b00001));
      check("reset res", res_out, '0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].res);

      run_and_check("big", 64'h66FFE53674D8AD58, 64'h53CE65B0C1F8D001, 64'h31986649780FA7EF,
                    ref_pow(64'h66FFE53674D8AD58, 64'h53CE65B0C1F8D001, 64'h31986649780FA7EF));

      for (int i = 0; i < 3; i++) begin
         rm = {$urandom(), $urandom()};
         re = {$urandom(), $urandom()};
         rn = {$urandom(), $urandom()} | 64'd1;
         if (rn == 64'd1) rn = 64'd3;
         run_and_check($sformatf("rnd%0d", i), rm, re, rn, ref_pow(rm, re, rn));
      end

      // Start held high; operands change after LOAD; stray ack mid-run.
      m_input = 64'd4; e_input = 64'd13; n_input = 64'd497;
      startInput = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_input = 64'd3; e_input = 64'd5; n_input = 64'd1001;
      ack();
      check("hold ack ignored", W'(state), W'(2));
      wait_end();
      $display("run hold1: res=0x%0h exp=0x%0h", res_out, 64'd445);
      check("hold1 res", res_out, 64'd445);
      repeat (5) @(negedge clk);
      check("hold1 stays done", W'(state), W'(9));
      ack();
      check("hold1 idle", W'(state), W'(0));
      @(negedge clk);
      check("hold2 load", W'(state), W'(1));
      @(negedge clk);
      startInput = 1'b0;
      wait_end();
      $display("run hold2: res=0x%0h exp=0x%0h", res_out, 64'd243);
      check("hold2 res", res_out, 64'd243);
      repeat (5) @(negedge clk);
      check("hold2 stays done", W'(state), W'(9));
      ack();
      repeat (5) @(negedge clk);
      check("hold2 no rerun", W'(state), W'(0));
      check("hold2 res held", res_out, 64'd243);

      // Reset in the middle of the square phase.
      start_run(64'd4, 64'd13, 64'd497);
      cyc = 0;
      while (state != 4'd5 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("reached sqr", W'(state), W'(5));
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      $display("run midreset: state=%0d exp_state=%b res=0x%0h", state, exp_state, res_out);
      check("midreset state", W'(state), W'(0));
      check("midreset exp_state", W'(exp_state), W'(5'b00001));
      check("midreset res", res_out, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_and_check("rerun", 64'd4, 64'd13, 64'd497, 64'd445);

      // Even modulus.
      start_run(64'd12345, 64'd3, 64'hF72D58F492D5B712);
      wait_end();
      $display("run even_n: state=%0d res=0x%0h", state, res_out);
`ifdef MONPRO_EVEN_N_CHECK_EN
      check("even state", W'(state), W'(10));
      check("even res", res_out, '0);
      check("even exp_state", W'(exp_state), W'(5'b00001));
`else
      check("even state", W'(state), W'(9));
`endif
      ack();
      check("even idle", W'(state), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
